// File: rtl/except_pkg.sv
// rtl/except_pkg.sv - exception request type shared by except and except_ctrl
package except_pkg;

  localparam logic [4:0] EXCCODE_INT = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] extra;
    logic        delayslot;
    logic [31:0] except_vec;
  } except_req_t;

endpackage

// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - ordered exception/ERET commit: wait mem, write CP0, flush, redirect fetch
// Optional statistics counters enabled by defining EXCEPT_CTRL_STATS_EN.
module except_ctrl
  import except_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  except_req_t except_req,
  input  logic        mem_busy,
  output logic        busy,
  output logic        flush,
  output logic        cp0_exc_we,
  output logic        cp0_eret_we,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_exc_pc,
  output logic [31:0] cp0_exc_extra,
  output logic        cp0_exc_delayslot,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
`ifdef EXCEPT_CTRL_STATS_EN
  ,
  output logic [31:0] stat_exc_count,
  output logic [31:0] stat_int_count,
  output logic [31:0] stat_eret_count
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_MEM, COMMIT, FLUSH, REDIRECT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          eret_q;
  logic          accept;

  // An ERET request counts as valid even if the valid bit itself is low.
  assign accept = (state == IDLE) && (except_req.valid || except_req.eret);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      eret_q            <= 1'b0;
      cp0_exc_code      <= '0;
      cp0_exc_pc        <= '0;
      cp0_exc_extra     <= '0;
      cp0_exc_delayslot <= 1'b0;
      redirect_pc       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        eret_q            <= except_req.eret;
        cp0_exc_code      <= except_req.code;
        cp0_exc_pc        <= except_req.pc;
        cp0_exc_extra     <= except_req.extra;
        cp0_exc_delayslot <= except_req.delayslot;
        redirect_pc       <= except_req.except_vec;
      end
      if (state == COMMIT)
        cnt <= CW'(FLUSH_CYCLES);
      else if (state == FLUSH && cnt != CW'(1))
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b1;
    flush          = 1'b0;
    cp0_exc_we     = 1'b0;
    cp0_eret_we    = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = mem_busy ? WAIT_MEM : COMMIT;
      end
      WAIT_MEM: begin
        flush = 1'b1;
        if (!mem_busy) state_nxt = COMMIT;
      end
      COMMIT: begin
        flush       = 1'b1;
        cp0_exc_we  = !eret_q;
        cp0_eret_we = eret_q;
        state_nxt   = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt == CW'(1)) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef EXCEPT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_exc_count  <= '0;
      stat_int_count  <= '0;
      stat_eret_count <= '0;
    end else if (state == COMMIT) begin
      if (eret_q) begin
        if (stat_eret_count != 32'hFFFF_FFFF) stat_eret_count <= stat_eret_count + 32'd1;
      end else begin
        if (stat_exc_count != 32'hFFFF_FFFF) stat_exc_count <= stat_exc_count + 32'd1;
        if (cp0_exc_code == EXCCODE_INT && stat_int_count != 32'hFFFF_FFFF)
          stat_int_count <= stat_int_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// tb/tb_except_ctrl.sv - directed self-checking bench for except_ctrl
module tb_except_ctrl;
  import except_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  except_req_t except_req;
  logic        mem_busy;
  logic        busy, flush, cp0_exc_we, cp0_eret_we;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_exc_pc, cp0_exc_extra;
  logic        cp0_exc_delayslot;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
`ifdef EXCEPT_CTRL_STATS_EN
  logic [31:0] stat_exc_count, stat_int_count, stat_eret_count;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  except_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .except_req(except_req), .mem_busy(mem_busy),
    .busy(busy), .flush(flush), .cp0_exc_we(cp0_exc_we), .cp0_eret_we(cp0_eret_we),
    .cp0_exc_code(cp0_exc_code), .cp0_exc_pc(cp0_exc_pc), .cp0_exc_extra(cp0_exc_extra),
    .cp0_exc_delayslot(cp0_exc_delayslot), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
`ifdef EXCEPT_CTRL_STATS_EN
    , .stat_exc_count(stat_exc_count), .stat_int_count(stat_int_count),
    .stat_eret_count(stat_eret_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic eret, input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] extra, input logic ds, input logic [31:0] vec);
    except_req.valid      = !eret;
    except_req.eret       = eret;
    except_req.code       = code;
    except_req.pc         = pc;
    except_req.extra      = extra;
    except_req.delayslot  = ds;
    except_req.except_vec = vec;
  endtask

  // Checks the control outputs in one cycle: {busy, flush, exc_we, eret_we, redirect_valid}.
  task automatic ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, busy, flush, cp0_exc_we, cp0_eret_we, redirect_valid}, {27'd0, exp});
  endtask

  task automatic run_plain(input logic eret, input logic [4:0] code);
    set_req(eret, code, 32'h8000_2000, 32'd0, 1'b0, 32'hBFC0_0380);
    tick();
    except_req = '0;
    repeat (FC + 2) tick();
  endtask

  initial begin
    rst = 1'b1;
    except_req = '0;
    mem_busy = 1'b0;
    redirect_ready = 1'b1;
    tick(); tick();
    ctl("reset_ctl", 5'b00000);
    check("reset_code", {27'd0, cp0_exc_code}, 32'd0);
    check("reset_pc", cp0_exc_pc, 32'd0);
    check("reset_extra", cp0_exc_extra, 32'd0);
    check("reset_ds", {31'd0, cp0_exc_delayslot}, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);
    rst = 1'b0;
    tick();
    ctl("idle_ctl", 5'b00000);

    // Syscall, memory idle, ready held high
    set_req(1'b0, 5'd8, 32'h8000_0100, 32'h0000_1234, 1'b1, 32'hBFC0_0380);
    tick();
    except_req = '0;
    ctl("sys_commit", 5'b11100);
    check("sys_code", {27'd0, cp0_exc_code}, 32'd8);
    check("sys_pc", cp0_exc_pc, 32'h8000_0100);
    check("sys_extra", cp0_exc_extra, 32'h0000_1234);
    check("sys_ds", {31'd0, cp0_exc_delayslot}, 32'd1);
    tick(); ctl("sys_flush1", 5'b11000);
    tick(); ctl("sys_flush2", 5'b11000);
    tick(); ctl("sys_redirect", 5'b10001);
    check("sys_rpc", redirect_pc, 32'hBFC0_0380);
    tick(); ctl("sys_idle", 5'b00000);

    // Same request with three WAIT_MEM cycles
    mem_busy = 1'b1;
    set_req(1'b0, 5'd8, 32'h8000_0100, 32'h0000_1234, 1'b1, 32'hBFC0_0380);
    tick();
    except_req = '0;
    ctl("mem_wait1", 5'b11000);
    tick(); ctl("mem_wait2", 5'b11000);
    tick(); ctl("mem_wait3", 5'b11000);
    mem_busy = 1'b0;
    tick(); ctl("mem_commit_t4", 5'b11100);
    tick(); tick();
    ctl("mem_flush_t6", 5'b11000);
    tick(); ctl("mem_redirect_t7", 5'b10001);
    tick(); ctl("mem_idle", 5'b00000);

    // ERET
    set_req(1'b1, 5'd0, 32'h8000_0200, 32'd0, 1'b0, 32'h8000_1234);
    tick();
    except_req = '0;
    ctl("eret_commit", 5'b11010);
    tick(); ctl("eret_flush1", 5'b11000);
    tick(); ctl("eret_flush2", 5'b11000);
    tick(); ctl("eret_redirect", 5'b10001);
    check("eret_rpc", redirect_pc, 32'h8000_1234);
    tick(); ctl("eret_idle", 5'b00000);

    // Second request during FLUSH is dropped; redirect held while ready low
    redirect_ready = 1'b0;
    set_req(1'b0, 5'd4, 32'h8000_0300, 32'h0000_0abc, 1'b0, 32'h8000_0180);
    tick();
    except_req = '0;
    tick();
    set_req(1'b0, 5'd5, 32'h9000_0000, 32'h1111_1111, 1'b1, 32'h1111_0000);
    tick();
    except_req = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      ctl($sformatf("hold_ctl%0d", i), 5'b10001);
      check($sformatf("hold_rpc%0d", i), redirect_pc, 32'h8000_0180);
      if (i < 4) tick();
    end
    check("hold_code", {27'd0, cp0_exc_code}, 32'd4);
    redirect_ready = 1'b1;
    tick(); ctl("hold_idle", 5'b00000);
    tick(); ctl("hold_no_requeue", 5'b00000);

    // Reset during FLUSH with a coincident request
    set_req(1'b0, 5'd12, 32'h8000_0400, 32'd0, 1'b0, 32'h8000_0180);
    tick();
    except_req = '0;
    tick();
    ctl("rst_pre_flush", 5'b11000);
    rst = 1'b1;
    set_req(1'b0, 5'd13, 32'h8000_0500, 32'h5, 1'b1, 32'h8000_0999);
    tick();
    rst = 1'b0;
    except_req = '0;
    ctl("rst_ctl", 5'b00000);
    check("rst_code", {27'd0, cp0_exc_code}, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    tick(); ctl("rst_not_latched", 5'b00000);
    set_req(1'b0, 5'd10, 32'h8000_0600, 32'd0, 1'b0, 32'hBFC0_0200);
    tick();
    except_req = '0;
    ctl("post_rst_commit", 5'b11100);
    check("post_rst_code", {27'd0, cp0_exc_code}, 32'd10);
    tick(); tick();
    ctl("post_rst_flush", 5'b11000);
    tick(); ctl("post_rst_redirect", 5'b10001);
    check("post_rst_rpc", redirect_pc, 32'hBFC0_0200);
    tick(); ctl("post_rst_idle", 5'b00000);

`ifdef EXCEPT_CTRL_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stat_reset", stat_exc_count, 32'd0);
    for (int i = 0; i < 3; i++) run_plain(1'b0, EXCCODE_INT);
    run_plain(1'b1, 5'd0);
    check("stat_int", stat_int_count, 32'd3);
    check("stat_exc", stat_exc_count, 32'd3);
    check("stat_eret", stat_eret_count, 32'd1);
`else
    run_plain(1'b0, 5'd9);
    ctl("plain_idle", 5'b00000);
    check("plain_code", {27'd0, cp0_exc_code}, 32'd9);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
